// File: rtl/shift_register_rx.sv
// Serial-to-parallel receiver: oversamples an asynchronous serial clock/data pair
// and assembles MSB-first frames of WIDTH bits, discarding stalled partial frames.
module shift_register_rx #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_serial_clk,
  input  logic             i_serial_data,
  output logic [WIDTH-1:0] o_parallel_data,
  output logic             o_data_stb,
  output logic             o_busy,
  output logic             o_timeout_stb
);

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int IDLE_W      = $clog2(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  // Synchronizer chains; the clock path carries one extra history flop for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] sdat_sync_reg;
  logic                   sclk_hist_reg;

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    shift_reg, shift_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [IDLE_W-1:0]   idle_reg, idle_next;
  logic [WIDTH-1:0]    data_reg, data_next;
  logic                dstb_reg, dstb_next;
  logic                tstb_reg, tstb_next;

  logic serial_rise;
  logic accept;
  logic rx_bit;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      // Clock path resets high so a serial clock held high across release is not an edge.
      sclk_sync_reg <= '1;
      sclk_hist_reg <= 1'b1;
      sdat_sync_reg <= '0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], i_serial_clk};
      sclk_hist_reg <= sclk_sync_reg[SYNC_STAGES-1];
      sdat_sync_reg <= {sdat_sync_reg[SYNC_STAGES-2:0], i_serial_data};
    end
  end

  assign serial_rise = sclk_sync_reg[SYNC_STAGES-1] & ~sclk_hist_reg;
  assign accept      = serial_rise & i_en;
  assign rx_bit      = sdat_sync_reg[SYNC_STAGES-1];
  assign shifted     = {shift_reg[WIDTH-2:0], rx_bit};

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      count_reg <= '0;
      idle_reg  <= '0;
      data_reg  <= '0;
      dstb_reg  <= 1'b0;
      tstb_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      count_reg <= count_next;
      idle_reg  <= idle_next;
      data_reg  <= data_next;
      dstb_reg  <= dstb_next;
      tstb_reg  <= tstb_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    count_next = count_reg;
    idle_next  = idle_reg;
    data_next  = data_reg;
    dstb_next  = 1'b0;
    tstb_next  = 1'b0;

    if (!i_en) begin
      state_next = IDLE;
      shift_next = '0;
      count_next = '0;
      idle_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          idle_next = '0;
          if (accept) begin
            shift_next = shifted;
            count_next = CNT_W'(1);
            state_next = RECV;
          end
        end
        RECV: begin
          // An edge always beats a coincident timeout.
          if (accept) begin
            idle_next  = '0;
            shift_next = shifted;
            if (count_reg == LAST_BIT) begin
              data_next  = shifted;
              dstb_next  = 1'b1;
              count_next = '0;
              state_next = IDLE;
            end else begin
              count_next = count_reg + CNT_W'(1);
            end
          end else if (idle_reg == IDLE_LAST) begin
            tstb_next  = 1'b1;
            shift_next = '0;
            count_next = '0;
            idle_next  = '0;
            state_next = IDLE;
          end else begin
            idle_next = idle_reg + IDLE_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
          idle_next  = '0;
        end
      endcase
    end
  end

  assign o_parallel_data = data_reg;
  assign o_data_stb      = dstb_reg;
  assign o_timeout_stb   = tstb_reg;
  assign o_busy          = (state_reg == RECV);

endmodule

// File: tb/tb_shift_register_rx.sv
// Directed bench for shift_register_rx: table of frames plus hand-written
// sequences for timeout, reset, enable and held-high serial clock cases.
module tb_shift_register_rx;

  localparam int WIDTH = 8;
  localparam int TO    = 256;
  localparam int HALF  = 25;

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic             i_en = 1'b1;
  logic             i_serial_clk = 1'b0;
  logic             i_serial_data = 1'b0;
  logic [WIDTH-1:0] o_parallel_data;
  logic             o_data_stb;
  logic             o_busy;
  logic             o_timeout_stb;

  shift_register_rx #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_en            (i_en),
    .i_serial_clk    (i_serial_clk),
    .i_serial_data   (i_serial_data),
    .o_parallel_data (o_parallel_data),
    .o_data_stb      (o_data_stb),
    .o_busy          (o_busy),
    .o_timeout_stb   (o_timeout_stb)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int dstb_cnt = 0;
  int tstb_cnt = 0;
  int last_dstb_cyc = 0;
  int last_tstb_cyc = 0;
  int rise_cyc = 0;
  logic [WIDTH-1:0] prev_data = '0;
  logic prev_rst = 1'b0;

  // Continuous watch on strobes and on the output word changing without a strobe.
  always @(negedge i_clk) begin
    if (o_data_stb) begin
      dstb_cnt++;
      last_dstb_cyc = cyc;
    end
    if (o_timeout_stb) begin
      tstb_cnt++;
      last_tstb_cyc = cyc;
    end
    if (o_data_stb && o_timeout_stb) begin
      checks++;
      errors++;
      $display("FAIL both_strobes: data_stb=%0b timeout_stb=%0b, required not both high", o_data_stb, o_timeout_stb);
    end
    if (o_parallel_data !== prev_data && !o_data_stb && i_reset_n && prev_rst) begin
      checks++;
      errors++;
      $display("FAIL data_change_no_stb: got %02h from %02h without strobe", o_parallel_data, prev_data);
    end
    prev_data = o_parallel_data;
    prev_rst  = i_reset_n;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    i_serial_data = b;
    tick(5);
    i_serial_clk = 1'b1;
    rise_cyc = cyc;
    tick(HALF);
    i_serial_clk = 1'b0;
    tick(HALF - 5);
  endtask

  task automatic send_bits(input logic [7:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(f[7-i]);
  endtask

  // Full frame with busy, strobe count, value and latency checks.
  task automatic run_frame(input string name, input logic [7:0] f, input logic [7:0] exp);
    int d0, t0;
    d0 = dstb_cnt;
    t0 = tstb_cnt;
    send_bit(f[7]);
    check({name, "_busy_mid"}, {31'd0, o_busy}, 32'd1);
    for (int i = 1; i < 8; i++) send_bit(f[7-i]);
    check({name, "_stb_count"}, dstb_cnt - d0, 32'd1);
    check({name, "_data"}, {24'd0, o_parallel_data}, {24'd0, exp});
    check({name, "_latency"}, last_dstb_cyc - rise_cyc, 32'd3);
    check({name, "_no_timeout"}, tstb_cnt - t0, 32'd0);
    check({name, "_busy_after"}, {31'd0, o_busy}, 32'd0);
    $display("frame %s sent %02h received %02h", name, f, o_parallel_data);
  endtask

  typedef struct {
    string      name;
    logic [7:0] frame;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0, t0, r5;
    logic [7:0] pd;

    vecs[0] = '{"a5", 8'hA5, 8'hA5};
    vecs[1] = '{"3c", 8'h3C, 8'h3C};
    vecs[2] = '{"c3", 8'hC3, 8'hC3};
    vecs[3] = '{"00", 8'h00, 8'h00};
    vecs[4] = '{"ff", 8'hFF, 8'hFF};

    tick(4);
    check("rst_data", {24'd0, o_parallel_data}, 32'd0);
    check("rst_dstb", {31'd0, o_data_stb}, 32'd0);
    check("rst_tstb", {31'd0, o_timeout_stb}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    i_reset_n = 1'b1;
    tick(5);

    // Consecutive entries are sent with no gap between frames.
    for (int v = 0; v < 5; v++) run_frame(vecs[v].name, vecs[v].frame, vecs[v].exp_data);

    // Timeout on a 5-bit partial frame.
    d0 = dstb_cnt;
    t0 = tstb_cnt;
    pd = o_parallel_data;
    send_bits(8'hFF, 5);
    r5 = rise_cyc;
    for (int k = 0; k < 400 && tstb_cnt == t0; k++) tick(1);
    check("to_count", tstb_cnt - t0, 32'd1);
    check("to_latency", last_tstb_cyc - r5, TO + 3);
    check("to_no_dstb", dstb_cnt - d0, 32'd0);
    check("to_data_kept", {24'd0, o_parallel_data}, {24'd0, pd});
    check("to_busy", {31'd0, o_busy}, 32'd0);
    $display("timeout after 5 bits: latency %0d cycles", last_tstb_cyc - r5);
    run_frame("81", 8'h81, 8'h81);

    // Reset pulse mid-frame.
    send_bits(8'hF0, 4);
    d0 = dstb_cnt;
    i_reset_n = 1'b0;
    tick(3);
    check("midrst_data", {24'd0, o_parallel_data}, 32'd0);
    check("midrst_busy", {31'd0, o_busy}, 32'd0);
    i_reset_n = 1'b1;
    tick(2);
    check("midrst_no_stb", dstb_cnt - d0, 32'd0);
    $display("reset pulse after 4 bits: data %02h", o_parallel_data);
    run_frame("5a", 8'h5A, 8'h5A);

    // Disable mid-frame, edges while disabled must be ignored.
    send_bits(8'hE0, 3);
    d0 = dstb_cnt;
    t0 = tstb_cnt;
    i_en = 1'b0;
    tick(2);
    check("dis_busy", {31'd0, o_busy}, 32'd0);
    send_bits(8'hF8, 5);
    check("dis_no_dstb", dstb_cnt - d0, 32'd0);
    check("dis_no_tstb", tstb_cnt - t0, 32'd0);
    check("dis_data_kept", {24'd0, o_parallel_data}, 32'h5A);
    i_en = 1'b1;
    $display("disabled after 3 bits plus 5 ignored edges");
    run_frame("96", 8'h96, 8'h96);

    // Serial clock held high across reset release must not count as an edge.
    i_serial_clk = 1'b1;
    tick(3);
    i_reset_n = 1'b0;
    tick(3);
    i_reset_n = 1'b1;
    tick(10);
    check("hold_busy", {31'd0, o_busy}, 32'd0);
    i_serial_clk = 1'b0;
    tick(20);
    check("hold_busy_low", {31'd0, o_busy}, 32'd0);
    $display("serial clock held high through reset release");
    run_frame("0f", 8'h0F, 8'h0F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
